// File: rtl/payload_writer.sv
// Byte-serial ingress stage: admits whole packets against buffer capacity, packs bytes into
// DATA_BYTES-wide blocks for the payload buffer and emits a descriptor per packet.
// Optional: define PAYLOAD_WRITER_DROP_CNT_EN to add a saturating capacity-reject counter.
module payload_writer #(
  parameter int DATA_BYTES = 4,
  parameter int ADDR_W     = 8,
  parameter int CAP_W      = 9,
  parameter int TTL_W      = 2,
  parameter int LEN_W      = 11,
  localparam int BC_W      = $clog2(DATA_BYTES)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              in_data,
  input  logic                    in_sop,
  input  logic                    in_eop,
  input  logic [LEN_W-1:0]        in_len,
  input  logic [TTL_W-1:0]        in_ttl,
  output logic                    buf_enable,
  output logic                    buf_read_write,
  output logic [8*DATA_BYTES-1:0] buf_data,
  output logic [TTL_W-1:0]        buf_ttl,
  output logic [BC_W-1:0]         buf_byte_count,
  output logic                    buf_is_last,
  input  logic [ADDR_W-1:0]       buf_address,
  input  logic [CAP_W-1:0]        buf_capacity,
`ifdef PAYLOAD_WRITER_DROP_CNT_EN
  output logic [15:0]             drop_count,
`endif
  output logic                    desc_valid,
  input  logic                    desc_ready,
  output logic [ADDR_W-1:0]       desc_address,
  output logic [LEN_W-1:0]        desc_blocks,
  output logic [TTL_W-1:0]        desc_ttl
);

  typedef enum logic [1:0] {IDLE, ACCEPT, DROP, DESC} state_e;

  state_e                  state_q, state_d;
  logic [8*DATA_BYTES-1:0] acc_q, acc_d, bdata_q, bdata_d;
  logic [BC_W-1:0]         cnt_q, cnt_d, bcnt_q, bcnt_d;
  logic                    benable_q, benable_d, blast_q, blast_d;
  logic                    first_q, first_d, trunc_q, trunc_d;
  logic [TTL_W-1:0]        ttl_q, ttl_d;
  logic [LEN_W-1:0]        need_q, need_d, blk_q, blk_d, dblocks_q, dblocks_d;
  logic [ADDR_W-1:0]       daddr_q, daddr_d;

  logic                    accept, fits, do_pack, overrun;
  logic [LEN_W-1:0]        need_in, need_base, blk_base;
  logic [BC_W-1:0]         pos;
  logic [8*DATA_BYTES-1:0] acc_ins;

  // Blocks needed for the announced length; a zero length still reserves one block.
  always_comb begin
    need_in = (in_len >> BC_W) + LEN_W'(|in_len[BC_W-1:0]);
    if (in_len == '0) need_in = LEN_W'(1);
    fits = (32'(need_in) <= 32'(buf_capacity));
  end

  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      IDLE:         in_ready = !benable_q;
      ACCEPT, DROP: in_ready = 1'b1;
      default:      in_ready = 1'b0;
    endcase
    if (reset) in_ready = 1'b0;
  end

  assign accept = in_valid && in_ready;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    bdata_d   = bdata_q;
    bcnt_d    = bcnt_q;
    blast_d   = blast_q;
    benable_d = 1'b0;
    first_d   = first_q;
    trunc_d   = trunc_q;
    ttl_d     = ttl_q;
    need_d    = need_q;
    blk_d     = blk_q;
    dblocks_d = dblocks_q;
    daddr_d   = daddr_q;
    do_pack   = 1'b0;
    overrun   = 1'b0;
    acc_ins   = '0;

    if (benable_q) begin
      dblocks_d = dblocks_q + LEN_W'(1);
      if (first_q) begin
        daddr_d = buf_address;
        first_d = 1'b0;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (accept && in_sop) begin
          if (fits) begin
            ttl_d     = in_ttl;
            need_d    = need_in;
            blk_d     = '0;
            dblocks_d = '0;
            first_d   = 1'b1;
            trunc_d   = 1'b0;
            do_pack   = 1'b1;
            state_d   = ACCEPT;
          end else begin
            trunc_d = 1'b0;
            state_d = DROP;
          end
        end
      end
      ACCEPT: begin
        if (accept && in_sop) begin
          // A new sop closes the current packet; with an empty accumulator there is nothing left to write.
          if (cnt_q != '0) begin
            bdata_d   = acc_q;
            bcnt_d    = cnt_q - BC_W'(1);
            blast_d   = 1'b1;
            benable_d = 1'b1;
          end
          acc_d   = '0;
          cnt_d   = '0;
          state_d = DESC;
        end else if (accept) begin
          do_pack = 1'b1;
        end
      end
      DROP: begin
        if (accept && in_eop) state_d = trunc_q ? DESC : IDLE;
      end
      DESC: begin
        if (desc_ready && !benable_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    pos       = (state_q == IDLE) ? '0 : cnt_q;
    blk_base  = (state_q == IDLE) ? '0 : blk_q;
    need_base = (state_q == IDLE) ? need_in : need_q;
    if (do_pack) begin
      acc_ins = (state_q == IDLE) ? '0 : acc_q;
      acc_ins[{pos, 3'b000} +: 8] = in_data;
      if (in_eop || pos == BC_W'(DATA_BYTES - 1)) begin
        overrun   = !in_eop && (blk_base + LEN_W'(1) == need_base);
        bdata_d   = acc_ins;
        bcnt_d    = pos;
        blast_d   = in_eop || overrun;
        benable_d = 1'b1;
        acc_d     = '0;
        cnt_d     = '0;
        blk_d     = blk_base + LEN_W'(1);
        if (in_eop) begin
          state_d = DESC;
        end else if (overrun) begin
          trunc_d = 1'b1;
          state_d = DROP;
        end
      end else begin
        acc_d = acc_ins;
        cnt_d = pos + BC_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      bdata_q   <= '0;
      bcnt_q    <= '0;
      blast_q   <= 1'b0;
      benable_q <= 1'b0;
      first_q   <= 1'b0;
      trunc_q   <= 1'b0;
      ttl_q     <= '0;
      need_q    <= '0;
      blk_q     <= '0;
      dblocks_q <= '0;
      daddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      bdata_q   <= bdata_d;
      bcnt_q    <= bcnt_d;
      blast_q   <= blast_d;
      benable_q <= benable_d;
      first_q   <= first_d;
      trunc_q   <= trunc_d;
      ttl_q     <= ttl_d;
      need_q    <= need_d;
      blk_q     <= blk_d;
      dblocks_q <= dblocks_d;
      daddr_q   <= daddr_d;
    end
  end

`ifdef PAYLOAD_WRITER_DROP_CNT_EN
  logic [15:0] drop_q;
  logic        drop_inc;
  assign drop_inc = (state_q == IDLE) && accept && in_sop && !fits;
  always_ff @(posedge clock) begin
    if (reset)                               drop_q <= '0;
    else if (drop_inc && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
  end
  assign drop_count = drop_q;
`endif

  assign buf_enable     = benable_q;
  assign buf_read_write = 1'b1;
  assign buf_data       = bdata_q;
  assign buf_ttl        = ttl_q;
  assign buf_byte_count = bcnt_q;
  assign buf_is_last    = blast_q;
  // Descriptor is presented only once the final block write has been counted.
  assign desc_valid     = (state_q == DESC) && !benable_q;
  assign desc_address   = daddr_q;
  assign desc_blocks    = dblocks_q;
  assign desc_ttl       = ttl_q;

endmodule

// File: tb/tb_payload_writer.sv
// Self-checking bench for payload_writer: table-driven packets plus hand-written corner sequences,
// with a scoreboard of expected block writes and descriptors.
module tb_payload_writer;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_sop, in_eop;
  logic [7:0]  in_data;
  logic [10:0] in_len;
  logic [1:0]  in_ttl;
  logic        buf_enable, buf_read_write, buf_is_last;
  logic [31:0] buf_data;
  logic [1:0]  buf_ttl, buf_byte_count;
  logic [7:0]  buf_address;
  logic [8:0]  buf_capacity;
  logic        desc_valid, desc_ready;
  logic [7:0]  desc_address;
  logic [10:0] desc_blocks;
  logic [1:0]  desc_ttl;
`ifdef PAYLOAD_WRITER_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  payload_writer dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop), .in_len(in_len), .in_ttl(in_ttl),
    .buf_enable(buf_enable), .buf_read_write(buf_read_write), .buf_data(buf_data),
    .buf_ttl(buf_ttl), .buf_byte_count(buf_byte_count), .buf_is_last(buf_is_last),
    .buf_address(buf_address), .buf_capacity(buf_capacity),
`ifdef PAYLOAD_WRITER_DROP_CNT_EN
    .drop_count(drop_count),
`endif
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_address(desc_address),
    .desc_blocks(desc_blocks), .desc_ttl(desc_ttl)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  bc;
    logic        last;
    logic [1:0]  ttl;
  } wr_t;
  typedef struct {
    logic [10:0] blocks;
    logic [1:0]  ttl;
  } desc_t;
  typedef struct {
    int len;
    int nbytes;
    int ttl;
    int cap;
    int start;
    int exp_blocks;
    bit exp_drop;
  } vec_t;

  wr_t        wr_q[$];
  desc_t      desc_q[$];
  logic [7:0] addr_q[$];
  bit         wr_first = 1'b1;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Free-list head keeps moving so the descriptor address sampling point matters.
  initial begin
    buf_address = 8'h10;
    forever begin
      @(posedge clock);
      #2 buf_address = buf_address + 8'd3;
    end
  end

  always @(negedge clock) begin
    if (buf_enable) begin
      if (wr_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got data %0h with no write expected", buf_data);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        check("wr_data", buf_data, e.data);
        check("wr_byte_count", buf_byte_count, e.bc);
        check("wr_is_last", buf_is_last, e.last);
        check("wr_ttl", buf_ttl, e.ttl);
        check("wr_read_write", buf_read_write, 1'b1);
      end
      if (wr_first) begin
        addr_q.push_back(buf_address);
        wr_first = 1'b0;
      end
    end
    if (desc_valid && desc_ready) begin
      if (desc_q.size() == 0 || addr_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_desc: got blocks %0d with no descriptor expected", desc_blocks);
      end else begin
        desc_t d;
        d = desc_q.pop_front();
        check("desc_blocks", desc_blocks, d.blocks);
        check("desc_ttl", desc_ttl, d.ttl);
        check("desc_address", desc_address, addr_q.pop_front());
      end
      wr_first = 1'b1;
    end
  end

  // Reference packing: bytes start, start+1, ... cut at need*4 and split little-endian into blocks.
  task automatic expect_pkt(input int len, input int n, input int ttl, input int start, input int blocks);
    int need, written, cnt;
    wr_t w;
    desc_t d;
    need    = (len == 0) ? 1 : (len + 3) / 4;
    written = (n < need * 4) ? n : need * 4;
    for (int b = 0; b * 4 < written; b++) begin
      cnt    = (written - b * 4 < 4) ? written - b * 4 : 4;
      w.data = '0;
      for (int i = 0; i < cnt; i++) w.data[i*8 +: 8] = 8'(start + b * 4 + i);
      w.bc   = 2'(cnt - 1);
      w.last = (b * 4 + cnt == written);
      w.ttl  = 2'(ttl);
      wr_q.push_back(w);
    end
    d.blocks = 11'(blocks);
    d.ttl    = 2'(ttl);
    desc_q.push_back(d);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_byte(input logic [7:0] d, input logic sop, input logic eop,
                            input int len, input int ttl);
    bit r;
    int t;
    in_valid = 1'b1;
    in_data  = d;
    in_sop   = sop;
    in_eop   = eop;
    in_len   = 11'(len);
    in_ttl   = 2'(ttl);
    t = 0;
    do begin
      r = in_ready;
      step();
      t++;
    end while (!r && t < 100);
    if (!r) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: byte %0h not accepted within %0d cycles", d, t);
    end
  endtask

  task automatic send_pkt(input int len, input int n, input int ttl, input int start);
    for (int i = 0; i < n; i++)
      drive_byte(8'(start + i), i == 0, i == n - 1, len, ttl);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((wr_q.size() != 0 || desc_q.size() != 0) && t < 60) begin
      step();
      t++;
    end
    check(name, 64'(wr_q.size() + desc_q.size()), 64'd0);
    repeat (3) step();
  endtask

  vec_t vecs[8];
  int   exp_drops;

  initial begin
    vecs[0] = '{len: 8,  nbytes: 8,  ttl: 2, cap: 256, start: 8'h00, exp_blocks: 2, exp_drop: 0};
    vecs[1] = '{len: 5,  nbytes: 5,  ttl: 1, cap: 256, start: 8'h20, exp_blocks: 2, exp_drop: 0};
    vecs[2] = '{len: 12, nbytes: 12, ttl: 3, cap: 2,   start: 8'h30, exp_blocks: 0, exp_drop: 1};
    vecs[3] = '{len: 4,  nbytes: 7,  ttl: 0, cap: 10,  start: 8'h40, exp_blocks: 1, exp_drop: 0};
    vecs[4] = '{len: 0,  nbytes: 1,  ttl: 1, cap: 1,   start: 8'h50, exp_blocks: 1, exp_drop: 0};
    vecs[5] = '{len: 8,  nbytes: 3,  ttl: 2, cap: 5,   start: 8'h60, exp_blocks: 1, exp_drop: 0};
    vecs[6] = '{len: 9,  nbytes: 9,  ttl: 1, cap: 3,   start: 8'h70, exp_blocks: 3, exp_drop: 0};
    vecs[7] = '{len: 9,  nbytes: 9,  ttl: 2, cap: 2,   start: 8'h90, exp_blocks: 0, exp_drop: 1};
    exp_drops = 0;

    reset        = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    in_sop       = 1'b0;
    in_eop       = 1'b0;
    in_len       = '0;
    in_ttl       = '0;
    desc_ready   = 1'b1;
    buf_capacity = 9'd256;
    repeat (2) step();
    check("reset_in_ready", in_ready, 1'b0);
    check("reset_buf_enable", buf_enable, 1'b0);
    check("reset_desc_valid", desc_valid, 1'b0);
    reset = 1'b0;
    step();
    check("idle_in_ready", in_ready, 1'b1);

    for (int i = 0; i < 8; i++) begin
      buf_capacity = 9'(vecs[i].cap);
      if (vecs[i].exp_drop) exp_drops++;
      else expect_pkt(vecs[i].len, vecs[i].nbytes, vecs[i].ttl, vecs[i].start, vecs[i].exp_blocks);
      send_pkt(vecs[i].len, vecs[i].nbytes, vecs[i].ttl, vecs[i].start);
      in_valid = 1'b0;
      drain($sformatf("drain_vec%0d", i));
    end
    buf_capacity = 9'd256;

    // Descriptor back-pressure: fields hold and the next sop waits for the handshake.
    begin
      int bad_ready, changed;
      logic [10:0] s_blocks;
      logic [7:0]  s_addr;
      logic [1:0]  s_ttl;
      int t;
      desc_ready = 1'b0;
      expect_pkt(4, 4, 3, 8'hA0, 1);
      send_pkt(4, 4, 3, 8'hA0);
      in_valid = 1'b0;
      t = 0;
      while (!desc_valid && t < 20) begin
        step();
        t++;
      end
      check("hold_desc_valid", desc_valid, 1'b1);
      check("hold_blocks", desc_blocks, 11'd1);
      check("hold_ttl", desc_ttl, 2'd3);
      s_blocks = desc_blocks;
      s_addr   = desc_address;
      s_ttl    = desc_ttl;
      bad_ready = 0;
      changed   = 0;
      in_valid = 1'b1;
      in_data  = 8'hB0;
      in_sop   = 1'b1;
      in_eop   = 1'b0;
      in_len   = 11'd4;
      in_ttl   = 2'd1;
      repeat (10) begin
        if (in_ready) bad_ready++;
        if (desc_blocks !== s_blocks || desc_address !== s_addr || desc_ttl !== s_ttl || !desc_valid)
          changed++;
        step();
      end
      check("hold_in_ready_cycles", 64'(bad_ready), 64'd0);
      check("hold_fields_changed", 64'(changed), 64'd0);
      desc_ready = 1'b1;
      expect_pkt(4, 4, 1, 8'hB0, 1);
      send_pkt(4, 4, 1, 8'hB0);
      in_valid = 1'b0;
      drain("drain_hold");
    end

    // Back-to-back packets with in_valid never dropped between them.
    expect_pkt(4, 4, 1, 8'hC0, 1);
    expect_pkt(4, 4, 2, 8'hC4, 1);
    send_pkt(4, 4, 1, 8'hC0);
    send_pkt(4, 4, 2, 8'hC4);
    in_valid = 1'b0;
    drain("drain_b2b");

    // sop inside a packet closes it; the interrupting sop byte is discarded.
    begin
      wr_t w;
      desc_t d;
      w = '{data: 32'h0000_D1D0, bc: 2'd1, last: 1'b1, ttl: 2'd2};
      wr_q.push_back(w);
      d = '{blocks: 11'd1, ttl: 2'd2};
      desc_q.push_back(d);
      drive_byte(8'hD0, 1'b1, 1'b0, 8, 2);
      drive_byte(8'hD1, 1'b0, 1'b0, 8, 2);
      drive_byte(8'hEE, 1'b1, 1'b0, 4, 1);
      in_valid = 1'b0;
      drain("drain_sop_mid");
    end

    // Reset mid-packet abandons it silently; the next packet goes through normally.
    drive_byte(8'hE0, 1'b1, 1'b0, 8, 1);
    drive_byte(8'hE1, 1'b0, 1'b0, 8, 1);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check("midreset_in_ready", in_ready, 1'b0);
    step();
    reset = 1'b0;
    check("midreset_buf_enable", buf_enable, 1'b0);
    check("midreset_desc_valid", desc_valid, 1'b0);
    repeat (4) step();
    expect_pkt(3, 3, 3, 8'hF0, 1);
    send_pkt(3, 3, 3, 8'hF0);
    in_valid = 1'b0;
    drain("drain_after_reset");

`ifdef PAYLOAD_WRITER_DROP_CNT_EN
    // Reset above cleared the counter; one more reject after it should read 1.
    check("drop_count_after_reset", drop_count, 16'd0);
    buf_capacity = 9'd1;
    send_pkt(8, 8, 1, 8'h00);
    in_valid = 1'b0;
    repeat (3) step();
    check("drop_count", drop_count, 16'd1);
    check("drops_in_table", 64'(exp_drops), 64'd2);
`endif

    check("final_addr_q_empty", 64'(addr_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
